// File: rtl/fp_accum_seq_if.sv
// rtl/fp_accum_seq_if.sv - sample stream, adder handshake and sum stream bundle for fp_accum_seq
interface fp_accum_seq_if #(
    parameter int EXPONENT = 8,
    parameter int MANTISSA = 23,
    parameter int COUNT_W  = 8
);
    localparam int W = EXPONENT + MANTISSA + 1;

    logic [COUNT_W-1:0] cfg_len;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_data;
    logic               add_start;
    logic [W-1:0]       add_a;
    logic [W-1:0]       add_b;
    logic               add_busy;
    logic               add_valid;
    logic [W-1:0]       add_result;
    logic               sum_valid;
    logic               sum_ready;
    logic [W-1:0]       sum_data;
    logic               exc;

    // Sequencer side: consumes samples, initiates adds, produces the block sum.
    modport master (
        input  cfg_len, in_valid, in_data, add_busy, add_valid, add_result, sum_ready,
        output in_ready, add_start, add_a, add_b, sum_valid, sum_data, exc
    );

    // Environment side: sample source, adder and sum consumer.
    modport slave (
        output cfg_len, in_valid, in_data, add_busy, add_valid, add_result, sum_ready,
        input  in_ready, add_start, add_a, add_b, sum_valid, sum_data, exc
    );
endinterface

// File: rtl/fp_accum_seq.sv
// rtl/fp_accum_seq.sv - block summing sequencer driving an external FP adder; FP_ACC_EXC_EN enables NaN/Inf flag
module fp_accum_seq #(
    parameter int EXPONENT = 8,
    parameter int MANTISSA = 23,
    parameter int COUNT_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    fp_accum_seq_if.master bus
);
    localparam int W = EXPONENT + MANTISSA + 1;
    localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [W-1:0]       smp_q, smp_d;
    logic [COUNT_W-1:0] len_q, len_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] cnt_inc;
    logic               in_ready_c;
    logic               add_start_c;

`ifdef FP_ACC_EXC_EN
    logic exc_q, exc_d;

    // All-ones exponent marks Inf or NaN.
    function automatic logic is_special(input logic [W-1:0] v);
        return &v[W-2 -: EXPONENT];
    endfunction
`endif

    assign cnt_inc = cnt_q + ONE;

    // Next-state and datapath selection for the block sequencer.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        smp_d       = smp_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        in_ready_c  = 1'b0;
        add_start_c = 1'b0;
`ifdef FP_ACC_EXC_EN
        exc_d       = exc_q;
`endif
        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    // First sample seeds the accumulator so the adder never sees a zero operand.
                    acc_d   = bus.in_data;
                    len_d   = (bus.cfg_len == '0) ? ONE : bus.cfg_len;
                    cnt_d   = ONE;
                    state_d = (len_d == ONE) ? S_DONE : S_ACC;
`ifdef FP_ACC_EXC_EN
                    exc_d   = exc_q | is_special(bus.in_data);
`endif
                end
            end
            S_ACC: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    smp_d   = bus.in_data;
                    state_d = S_ISSUE;
`ifdef FP_ACC_EXC_EN
                    exc_d   = exc_q | is_special(bus.in_data);
`endif
                end
            end
            S_ISSUE: begin
                if (!bus.add_busy) begin
                    add_start_c = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.add_valid) begin
                    acc_d   = bus.add_result;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? S_DONE : S_ACC;
`ifdef FP_ACC_EXC_EN
                    exc_d   = exc_q | is_special(bus.add_result);
`endif
                end
            end
            S_DONE: begin
                if (bus.sum_ready) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
`ifdef FP_ACC_EXC_EN
                    exc_d   = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any block in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            smp_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            smp_q   <= smp_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FP_ACC_EXC_EN
    // Sticky exception flag for the current block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_q <= 1'b0;
        end else begin
            exc_q <= exc_d;
        end
    end

    assign bus.exc = exc_q;
`else
    assign bus.exc = 1'b0;
`endif

    // in_ready is masked while reset is held since IDLE would otherwise advertise readiness.
    assign bus.in_ready  = rst & in_ready_c;
    assign bus.add_start = add_start_c;
    assign bus.add_a     = acc_q;
    assign bus.add_b     = smp_q;
    assign bus.sum_valid = (state_q == S_DONE);
    assign bus.sum_data  = acc_q;
endmodule

// File: tb/tb_fp_accum_seq.sv
// tb/tb_fp_accum_seq.sv - directed self-checking bench for fp_accum_seq with a 3-cycle adder model
module tb_fp_accum_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int errors = 0;
    int checks = 0;

    fp_accum_seq_if #(.EXPONENT(8), .MANTISSA(23), .COUNT_W(8)) bus ();

    fp_accum_seq #(.EXPONENT(8), .MANTISSA(23), .COUNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic        model_busy   = 1'b0;
    logic        hold_busy    = 1'b0;
    logic        model_valid  = 1'b0;
    logic [31:0] model_result = 32'h0;
    int          lat          = 0;
    int          start_cnt    = 0;
    logic [31:0] res_q[$];
    logic [31:0] cap_a[$];
    logic [31:0] cap_b[$];

    assign bus.add_busy   = model_busy | hold_busy;
    assign bus.add_valid  = model_valid;
    assign bus.add_result = model_result;

`ifdef FP_ACC_EXC_EN
    localparam logic EXC_EXP = 1'b1;
`else
    localparam logic EXC_EXP = 1'b0;
`endif

    // Adder model: start seen in cycle N0, busy through WAIT, result strobed in the third WAIT cycle.
    always @(negedge clk) begin
        #2;
        if (lat == 0) begin
            if (bus.add_start) begin
                cap_a.push_back(bus.add_a);
                cap_b.push_back(bus.add_b);
                start_cnt++;
                lat = 1;
            end
        end else if (lat == 1) begin
            model_busy = 1'b1;
            lat = 2;
        end else if (lat == 2) begin
            lat = 3;
        end else if (lat == 3) begin
            model_busy   = 1'b0;
            model_valid  = 1'b1;
            model_result = (res_q.size() > 0) ? res_q.pop_front() : 32'h0;
            lat = 4;
        end else begin
            model_valid = 1'b0;
            lat = 0;
        end
    end

    task automatic send(input logic [31:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL send_timeout in_ready=%0b required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_sum(output int cyc);
        cyc = 0;
        while (!bus.sum_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL sum_timeout sum_valid=%0b required 1", bus.sum_valid);
        end
    endtask

    task automatic handshake();
        bus.sum_ready = 1'b1;
        @(negedge clk);
        bus.sum_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks += 7;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); end
        if (bus.add_start !== 1'b0) begin errors++; $display("FAIL rst_add_start got=%0b exp=0", bus.add_start); end
        if (bus.add_a !== 32'h0) begin errors++; $display("FAIL rst_add_a got=%h exp=0", bus.add_a); end
        if (bus.add_b !== 32'h0) begin errors++; $display("FAIL rst_add_b got=%h exp=0", bus.add_b); end
        if (bus.sum_valid !== 1'b0) begin errors++; $display("FAIL rst_sum_valid got=%0b exp=0", bus.sum_valid); end
        if (bus.sum_data !== 32'h0) begin errors++; $display("FAIL rst_sum_data got=%h exp=0", bus.sum_data); end
        if (bus.exc !== 1'b0) begin errors++; $display("FAIL rst_exc got=%0b exp=0", bus.exc); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%0b exp=1", bus.in_ready); end
    endtask

    // cfg_len of 1 and 0 both yield a one-sample block with no add.
    task automatic test_single();
        logic [7:0]  lens[2];
        logic [31:0] vals[2];
        int s0;
        lens[0] = 8'd1; vals[0] = 32'h3F800000;
        lens[1] = 8'd0; vals[1] = 32'h40A00000;
        for (int i = 0; i < 2; i++) begin
            s0 = start_cnt;
            bus.cfg_len = lens[i];
            send(vals[i]);
            checks += 4;
            if (bus.sum_valid !== 1'b1) begin errors++; $display("FAIL single%0d_sum_valid got=%0b exp=1", i, bus.sum_valid); end
            if (bus.sum_data !== vals[i]) begin errors++; $display("FAIL single%0d_sum_data got=%h exp=%h", i, bus.sum_data, vals[i]); end
            if (bus.exc !== 1'b0) begin errors++; $display("FAIL single%0d_exc got=%0b exp=0", i, bus.exc); end
            handshake();
            if (start_cnt !== s0) begin errors++; $display("FAIL single%0d_starts got=%0d exp=%0d", i, start_cnt, s0); end
            checks++;
            if (bus.sum_valid !== 1'b0) begin errors++; $display("FAIL single%0d_sum_drop got=%0b exp=0", i, bus.sum_valid); end
        end
    endtask

    task automatic test_len3();
        int s0, cyc;
        s0 = start_cnt;
        cap_a.delete(); cap_b.delete();
        res_q.push_back(32'h40400000);
        res_q.push_back(32'h40C00000);
        bus.cfg_len = 8'd3;
        send(32'h3F800000);
        bus.cfg_len = 8'h55;
        send(32'h40000000);
        checks++;
        if (bus.add_start !== 1'b1) begin errors++; $display("FAIL len3_issue_start got=%0b exp=1", bus.add_start); end
        send(32'h40400000);
        wait_sum(cyc);
        checks += 4;
        if (cyc !== 4) begin errors++; $display("FAIL len3_latency got=%0d exp=4", cyc); end
        if (start_cnt - s0 !== 2) begin errors++; $display("FAIL len3_starts got=%0d exp=2", start_cnt - s0); end
        if (bus.sum_data !== 32'h40C00000) begin errors++; $display("FAIL len3_sum got=%h exp=40c00000", bus.sum_data); end
        if (bus.exc !== 1'b0) begin errors++; $display("FAIL len3_exc got=%0b exp=0", bus.exc); end
        if (cap_a.size() == 2 && cap_b.size() == 2) begin
            checks += 4;
            if (cap_a[0] !== 32'h3F800000) begin errors++; $display("FAIL len3_a0 got=%h exp=3f800000", cap_a[0]); end
            if (cap_b[0] !== 32'h40000000) begin errors++; $display("FAIL len3_b0 got=%h exp=40000000", cap_b[0]); end
            if (cap_a[1] !== 32'h40400000) begin errors++; $display("FAIL len3_a1 got=%h exp=40400000", cap_a[1]); end
            if (cap_b[1] !== 32'h40400000) begin errors++; $display("FAIL len3_b1 got=%h exp=40400000", cap_b[1]); end
        end
        handshake();
    endtask

    task automatic test_busy();
        int s0, cyc;
        s0 = start_cnt;
        res_q.push_back(32'h3FC00000);
        hold_busy = 1'b1;
        bus.cfg_len = 8'd2;
        send(32'h3F800000);
        send(32'h3F000000);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks += 3;
            if (bus.add_start !== 1'b0) begin errors++; $display("FAIL busy_withheld%0d got=%0b exp=0", i, bus.add_start); end
            if (bus.add_a !== 32'h3F800000) begin errors++; $display("FAIL busy_a%0d got=%h exp=3f800000", i, bus.add_a); end
            if (bus.add_b !== 32'h3F000000) begin errors++; $display("FAIL busy_b%0d got=%h exp=3f000000", i, bus.add_b); end
            @(negedge clk);
        end
        hold_busy = 1'b0;
        #1;
        checks++;
        if (bus.add_start !== 1'b1) begin errors++; $display("FAIL busy_release_start got=%0b exp=1", bus.add_start); end
        @(negedge clk);
        @(negedge clk);
        checks += 3;
        if (bus.add_start !== 1'b0) begin errors++; $display("FAIL busy_wait_start got=%0b exp=0", bus.add_start); end
        if (bus.add_a !== 32'h3F800000) begin errors++; $display("FAIL busy_wait_a got=%h exp=3f800000", bus.add_a); end
        if (bus.add_b !== 32'h3F000000) begin errors++; $display("FAIL busy_wait_b got=%h exp=3f000000", bus.add_b); end
        wait_sum(cyc);
        checks += 2;
        if (start_cnt - s0 !== 1) begin errors++; $display("FAIL busy_starts got=%0d exp=1", start_cnt - s0); end
        if (bus.sum_data !== 32'h3FC00000) begin errors++; $display("FAIL busy_sum got=%h exp=3fc00000", bus.sum_data); end
        handshake();
    endtask

    task automatic test_backpressure();
        bus.cfg_len = 8'd1;
        send(32'h40000000);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h40800000;
        for (int i = 0; i < 10; i++) begin
            checks += 3;
            if (bus.sum_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got=%0b exp=1", i, bus.sum_valid); end
            if (bus.sum_data !== 32'h40000000) begin errors++; $display("FAIL bp_data%0d got=%h exp=40000000", i, bus.sum_data); end
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got=%0b exp=0", i, bus.in_ready); end
            @(negedge clk);
        end
        handshake();
        checks += 2;
        if (bus.sum_valid !== 1'b0) begin errors++; $display("FAIL bp_after_valid got=%0b exp=0", bus.sum_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_ready got=%0b exp=1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks += 2;
        if (bus.sum_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got=%0b exp=1", bus.sum_valid); end
        if (bus.sum_data !== 32'h40800000) begin errors++; $display("FAIL bp_next_data got=%h exp=40800000", bus.sum_data); end
        handshake();
    endtask

    task automatic test_reset_mid();
        int s0;
        s0 = start_cnt;
        res_q.push_back(32'h12345678);
        bus.cfg_len = 8'd2;
        send(32'h3F800000);
        send(32'h40000000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got=%0b exp=0", bus.in_ready); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 4;
        if (start_cnt - s0 !== 1) begin errors++; $display("FAIL mid_starts got=%0d exp=1", start_cnt - s0); end
        if (bus.sum_valid !== 1'b0) begin errors++; $display("FAIL mid_sum_valid got=%0b exp=0", bus.sum_valid); end
        if (bus.sum_data !== 32'h0) begin errors++; $display("FAIL mid_acc got=%h exp=0", bus.sum_data); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_idle got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_exc();
        int cyc;
        res_q.push_back(32'h7F800000);
        bus.cfg_len = 8'd2;
        send(32'h3F800000);
        send(32'h7F800000);
        wait_sum(cyc);
        checks += 2;
        if (bus.sum_data !== 32'h7F800000) begin errors++; $display("FAIL exc_sum got=%h exp=7f800000", bus.sum_data); end
        if (bus.exc !== EXC_EXP) begin errors++; $display("FAIL exc_flag got=%0b exp=%0b", bus.exc, EXC_EXP); end
        handshake();
        checks++;
        if (bus.exc !== 1'b0) begin errors++; $display("FAIL exc_clear got=%0b exp=0", bus.exc); end
    endtask

    initial begin
        bus.cfg_len   = 8'd1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.sum_ready = 1'b0;
        test_reset();
        test_single();
        test_len3();
        test_busy();
        test_backpressure();
        test_reset_mid();
        test_exc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_accum_seq.md
# fp_accum_seq

Sequencer that sums a block of IEEE-754 single-precision samples by driving an external multi-cycle floating-point adder over its start/busy/valid handshake. Sits upstream of the adder as the initiator side: accepts samples on a valid/ready stream, issues one add per sample after the first, and presents the block sum on a valid/ready output. The first sample of each block is loaded directly into the accumulator, so the adder never sees a zero operand.

## Interface
- EXPONENT, 8, exponent field width
- MANTISSA, 23, fraction field width (word width W = EXPONENT+MANTISSA+1)
- COUNT_W, 8, width of block-length and sample counters
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- cfg_len  in  COUNT_W  samples per block; sampled when a block's first sample is accepted
- in_valid  in  1  sample present
- in_ready  out  1  block can accept a sample
- in_data  in  W  sample
- add_start  out  1  one-cycle request to adder
- add_a  out  W  operand A (accumulator)
- add_b  out  W  operand B (held sample)
- add_busy  in  1  adder computing
- add_valid  in  1  one-cycle result strobe
- add_result  in  W  adder sum
- sum_valid  out  1  block sum available
- sum_ready  in  1  consumer accepts sum
- sum_data  out  W  block sum
- exc  out  1  NaN/Inf seen in current block (see Configuration)

## Operation
- States: IDLE, ACC, ISSUE, WAIT, DONE.
- IDLE: in_ready=1. On accept: acc<=in_data, len_q<=(cfg_len==0 ? 1 : cfg_len), cnt<=1; go DONE if len_q==1, else ACC.
- ACC: in_ready=1. On accept: smp<=in_data, go ISSUE.
- ISSUE: add_start=1 for exactly this cycle, and only if add_busy==0; else stay ISSUE with add_start=0. Next state WAIT after start issued.
- WAIT: in_ready=0. On add_valid: acc<=add_result, cnt<=cnt+1; if cnt+1==len_q go DONE else ACC.
- DONE: sum_valid=1, sum_data=acc, held stable until sum_ready; on sum_valid&&sum_ready go IDLE, cnt<=0.
- add_a=acc and add_b=smp driven from registers, stable from ISSUE through end of WAIT.
- add_valid outside WAIT ignored (no state or acc change).
- cnt compare is exact equality at COUNT_W bits; cfg_len=2^COUNT_W-1 is max block; cfg_len changes mid-block have no effect.
- No arithmetic in this block beyond counter increment; all float math in the adder.

## Timing
- Reset values: in_ready=0 while rst low, then 1 (IDLE); add_start=0; add_a=0; add_b=0; sum_valid=0; sum_data=0; exc=0; state IDLE; cnt=0.
- Reset mid-block discards acc and counters; an adder result arriving after reset release is ignored (state IDLE).
- Per-sample cost after the first: 1 cycle accept + 1 cycle ISSUE + adder latency (3 cycles for the team adder) = 5 cycles when add_busy low.
- sum_valid asserts the cycle after the last add_valid (or after accepting a single-sample block).
- Simultaneous in_valid in DONE: not accepted (in_ready=0) until sum handshake completes; next block's first sample accepted no earlier than the cycle after IDLE is entered.

## Configuration
- FP_ACC_EXC_EN defined: exc sets (sticky) when any accepted in_data or captured add_result has exponent all ones; exc valid with sum_valid; cleared on sum handshake and reset.
- FP_ACC_EXC_EN undefined: exc tied 0, detection logic absent; sequencing identical.

## Test plan
- cfg_len=1, in_data=0x3F800000 -> no add_start; sum_valid next cycle, sum_data=0x3F800000.
- cfg_len=3, samples 0x3F800000, 0x40000000, 0x40400000, 3-cycle adder model -> exactly 2 add_start pulses, sum_data=0x40C00000.
- cfg_len=2, add_busy held high 4 cycles in ISSUE -> add_start withheld, then single pulse; add_a/add_b stable until add_valid; result 1.0+0.5=0x3FC00000.
- sum_ready held low 10 cycles -> sum_valid/sum_data stable, in_ready=0 throughout; next block starts after handshake.
- rst low during WAIT, adder completes after release -> state IDLE, sum_valid stays 0, acc not updated.
- FP_ACC_EXC_EN defined, cfg_len=2, second sample 0x7F800000 -> exc=1 with sum_valid, 0 after handshake; undefined -> exc=0.
